// File: rtl/ram_scan_pkg.sv
// Shared types and default widths for the display-RAM read scanner.
package ram_scan_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2
    } scan_state_t;

    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned DEF_DATA_W = 4;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: o_tick_c pulses on the terminal count while enabled.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick_c
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    // Disabled or cleared holds the count at zero so a new run starts a full period.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt <= '0;
        end else if (i_clr || !i_en || (r_cnt == CNT_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tick_c = i_en && !i_clr && (r_cnt == CNT_LAST);

endmodule

// File: rtl/ram_read_scanner.sv
// Read-side sequencer for the display RAM: steps/scans rd_addr, waits out read latency, latches addr/data.
// Define SCAN_AUTO_EN to build the run-driven auto-scan prescaler; otherwise only i_step advances.
module ram_read_scanner
    import ram_scan_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned TICK_DIV   = 50_000_000
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_step,
    input  logic              i_run,
    input  logic              i_clear,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [DATA_W-1:0] i_rd_q,
    output logic [ADDR_W-1:0] o_out_addr,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_out_valid,
    output logic              o_busy
);

    localparam int unsigned LAT_W = 2;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LATENCY - 1);

    scan_state_t       r_state,     w_state_nxt;
    logic [LAT_W-1:0]  r_lat_cnt,   w_lat_cnt_nxt;
    logic [ADDR_W-1:0] r_rd_addr,   w_rd_addr_nxt;
    logic [ADDR_W-1:0] r_out_addr,  w_out_addr_nxt;
    logic [DATA_W-1:0] r_out_data,  w_out_data_nxt;
    logic              r_out_valid, w_out_valid_nxt;
    logic              r_busy,      w_busy_nxt;
    logic              r_pend_adv,  w_pend_adv_nxt;
    logic              r_pend_ref,  w_pend_ref_nxt;
    logic              r_wr_en_d;
    logic [ADDR_W-1:0] r_wr_addr_d;
    logic              w_auto_tick;
    logic              w_adv_evt;
    logic              w_ref_evt;

`ifdef SCAN_AUTO_EN
    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_en      (i_run),
        .i_clr     (i_clear),
        .o_tick_c  (w_auto_tick)
    );
`else
    logic w_unused_run;
    assign w_unused_run = i_run | (TICK_DIV == 0);
    assign w_auto_tick  = 1'b0;
`endif

    // The RAM returns old data during the write cycle, so the hit is judged one cycle later.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_en_d   <= 1'b0;
            r_wr_addr_d <= '0;
        end else begin
            r_wr_en_d   <= i_wr_en;
            r_wr_addr_d <= i_wr_addr;
        end
    end

    assign w_adv_evt = i_step | w_auto_tick;
    assign w_ref_evt = r_wr_en_d && (r_wr_addr_d == r_out_addr);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= WAIT;
            r_lat_cnt   <= '0;
            r_rd_addr   <= '0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b1;
            r_pend_adv  <= 1'b0;
            r_pend_ref  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lat_cnt   <= w_lat_cnt_nxt;
            r_rd_addr   <= w_rd_addr_nxt;
            r_out_addr  <= w_out_addr_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_pend_adv  <= w_pend_adv_nxt;
            r_pend_ref  <= w_pend_ref_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_lat_cnt_nxt   = r_lat_cnt;
        w_rd_addr_nxt   = r_rd_addr;
        w_out_addr_nxt  = r_out_addr;
        w_out_data_nxt  = r_out_data;
        w_out_valid_nxt = 1'b0;
        w_pend_adv_nxt  = r_pend_adv;
        w_pend_ref_nxt  = r_pend_ref;

        if (i_clear) begin
            w_state_nxt    = WAIT;
            w_lat_cnt_nxt  = '0;
            w_rd_addr_nxt  = '0;
            w_pend_adv_nxt = 1'b0;
            w_pend_ref_nxt = 1'b0;
        end else begin
            // Events seen mid-fetch are parked; advance is one deep, extras are dropped.
            if (r_state != IDLE) begin
                if (w_adv_evt) begin
                    w_pend_adv_nxt = 1'b1;
                end
                if (w_ref_evt) begin
                    w_pend_ref_nxt = 1'b1;
                end
            end

            unique case (r_state)
                IDLE: begin
                    if (w_adv_evt || r_pend_adv) begin
                        w_rd_addr_nxt  = r_rd_addr + ADDR_W'(1);
                        w_state_nxt    = WAIT;
                        w_lat_cnt_nxt  = '0;
                        w_pend_adv_nxt = 1'b0;
                        w_pend_ref_nxt = 1'b0;
                    end else if (w_ref_evt || r_pend_ref) begin
                        w_state_nxt    = WAIT;
                        w_lat_cnt_nxt  = '0;
                        w_pend_ref_nxt = 1'b0;
                    end
                end
                WAIT: begin
                    w_lat_cnt_nxt = r_lat_cnt + LAT_W'(1);
                    if (r_lat_cnt == LAT_LAST) begin
                        w_state_nxt = CAPTURE;
                    end
                end
                CAPTURE: begin
                    w_out_data_nxt  = i_rd_q;
                    w_out_addr_nxt  = r_rd_addr;
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    assign o_rd_addr   = r_rd_addr;
    assign o_out_addr  = r_out_addr;
    assign o_out_data  = r_out_data;
    assign o_out_valid = r_out_valid;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_ram_read_scanner.sv
// Bench for ram_read_scanner: cycle-exact vector table plus sequences for wrap, clear, reset and auto-scan.
module tb_ram_read_scanner;

    localparam int unsigned AW  = 5;
    localparam int unsigned DW  = 4;
    localparam int unsigned LAT = 2;

    logic          clk;
    logic          rst_n;
    logic          step;
    logic          run;
    logic          clear;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_q;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          busy;

    int n_vec = 0;
    int n_bad = 0;

    ram_read_scanner #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .RD_LATENCY (LAT),
        .TICK_DIV   (8)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_step      (step),
        .i_run       (run),
        .i_clear     (clear),
        .i_wr_en     (wr_en),
        .i_wr_addr   (wr_addr),
        .o_rd_addr   (rd_addr),
        .i_rd_q      (rd_q),
        .o_out_addr  (out_addr),
        .o_out_data  (out_data),
        .o_out_valid (out_valid),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 32x4 RAM with a LAT-stage registered read port
    logic [DW-1:0] mem     [32];
    logic [DW-1:0] rd_pipe [LAT];

    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_pipe[0] <= mem[rd_addr];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign rd_q = rd_pipe[LAT-1];

    typedef struct {
        logic          step;
        logic          clear;
        logic          wr_en;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [AW-1:0] rd;
        logic [AW-1:0] oa;
        logic [DW-1:0] od;
        logic          v;
        logic          b;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic c, input logic w, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic [AW-1:0] erd, input logic [AW-1:0] eoa,
                       input logic [DW-1:0] eod, input logic ev, input logic eb);
        vec_t t;
        t.step = s; t.clear = c; t.wr_en = w; t.wa = wa; t.wd = wd;
        t.rd = erd; t.oa = eoa; t.od = eod; t.v = ev; t.b = eb;
        vecs.push_back(t);
    endtask

    task automatic idle(input int n, input logic [AW-1:0] erd, input logic [AW-1:0] eoa,
                        input logic [DW-1:0] eod);
        for (int i = 0; i < n; i++) add(0, 0, 0, 0, 0, erd, eoa, eod, 0, 0);
    endtask

    // One fetch started by a step from idle: 3 busy cycles then the capture pulse.
    task automatic fetch(input logic [AW-1:0] na, input logic [AW-1:0] oa, input logic [DW-1:0] od,
                         input logic [DW-1:0] nd);
        add(1, 0, 0, 0, 0, na, oa, od, 0, 1);
        add(0, 0, 0, 0, 0, na, oa, od, 0, 1);
        add(0, 0, 0, 0, 0, na, oa, od, 0, 1);
        add(0, 0, 0, 0, 0, na, na, nd, 1, 0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_step();
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (out_valid) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic count_valid(input int cycles, output int cnt);
        cnt = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
    endtask

`ifdef SCAN_AUTO_EN
    localparam int unsigned EXP_AUTO = 5;
    localparam logic [AW+DW-1:0] EXP_AUTO_OUT = {5'd5, 4'd6};
`else
    localparam int unsigned EXP_AUTO = 0;
    localparam logic [AW+DW-1:0] EXP_AUTO_OUT = {5'd0, 4'd0};
`endif

    initial begin
        int lat;
        int cnt;
        int bad_walk;

        for (int i = 0; i < 32; i++) mem[i] = '0;
        mem[1] = 4'hA; mem[2] = 4'hB; mem[3] = 4'hC;
        for (int i = 0; i < LAT; i++) rd_pipe[i] = '0;

        rst_n = 1'b0; step = 1'b0; run = 1'b0; clear = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (2) @(negedge clk);
        chk("reset_state", 32'({rd_addr, out_addr, out_data, out_valid, busy}),
            32'({5'd0, 5'd0, 4'd0, 1'b0, 1'b1}));
        rst_n = 1'b1;

        // Initial fetch of address 0 after reset.
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(1, 0, 0, 0);
        // Steps 10 clocks apart.
        fetch(1, 0, 0, 4'hA);  idle(6, 1, 1, 4'hA);
        fetch(2, 1, 4'hA, 4'hB); idle(6, 2, 2, 4'hB);
        // Write to the shown address refreshes; a write elsewhere does not.
        add(0, 0, 1, 2, 5, 2, 2, 4'hB, 0, 0);
        add(0, 0, 0, 0, 0, 2, 2, 4'hB, 0, 1);
        add(0, 0, 0, 0, 0, 2, 2, 4'hB, 0, 1);
        add(0, 0, 0, 0, 0, 2, 2, 4'hB, 0, 1);
        add(0, 0, 0, 0, 0, 2, 2, 4'h5, 1, 0);
        idle(2, 2, 2, 4'h5);
        add(0, 0, 1, 7, 9, 2, 2, 4'h5, 0, 0);
        idle(5, 2, 2, 4'h5);
        fetch(3, 2, 4'h5, 4'hC); idle(2, 3, 3, 4'hC);
        // Three back-to-back steps: one accepted, one pending, one dropped.
        add(1, 0, 0, 0, 0, 4, 3, 4'hC, 0, 1);
        add(1, 0, 0, 0, 0, 4, 3, 4'hC, 0, 1);
        add(1, 0, 0, 0, 0, 4, 3, 4'hC, 0, 1);
        add(0, 0, 0, 0, 0, 4, 4, 0, 1, 0);
        add(0, 0, 0, 0, 0, 5, 4, 0, 0, 1);
        add(0, 0, 0, 0, 0, 5, 4, 0, 0, 1);
        add(0, 0, 0, 0, 0, 5, 4, 0, 0, 1);
        add(0, 0, 0, 0, 0, 5, 5, 0, 1, 0);
        idle(4, 5, 5, 0);
        // Pending advance and pending refresh together: advance wins and drops the refresh.
        add(1, 0, 0, 0, 0, 6, 5, 0, 0, 1);
        add(1, 0, 1, 5, 6, 6, 5, 0, 0, 1);
        add(0, 0, 0, 0, 0, 6, 5, 0, 0, 1);
        add(0, 0, 0, 0, 0, 6, 6, 0, 1, 0);
        add(0, 0, 0, 0, 0, 7, 6, 0, 0, 1);
        add(0, 0, 0, 0, 0, 7, 6, 0, 0, 1);
        add(0, 0, 0, 0, 0, 7, 6, 0, 0, 1);
        add(0, 0, 0, 0, 0, 7, 7, 4'h9, 1, 0);
        idle(4, 7, 7, 4'h9);

        foreach (vecs[i]) begin
            step    = vecs[i].step;
            clear   = vecs[i].clear;
            wr_en   = vecs[i].wr_en;
            wr_addr = vecs[i].wa;
            wr_data = vecs[i].wd;
            @(negedge clk);
            chk($sformatf("vec%0d", i), 32'({rd_addr, out_addr, out_data, out_valid, busy}),
                32'({vecs[i].rd, vecs[i].oa, vecs[i].od, vecs[i].v, vecs[i].b}));
        end
        step = 1'b0; clear = 1'b0; wr_en = 1'b0;

        // Walk up to 31, then wrap to 0.
        bad_walk = 0;
        for (int a = 8; a <= 31; a++) begin
            pulse_step();
            wait_valid(lat);
            if (lat != 3) bad_walk++;
        end
        chk("walk_latency", 32'(bad_walk), 32'd0);
        chk("walk_to_31", 32'({out_addr, out_data}), 32'({5'd31, 4'd0}));
        pulse_step();
        chk("wrap_rd_addr", 32'(rd_addr), 32'd0);
        wait_valid(lat);
        chk("wrap_latency", 32'(lat), 32'd3);
        chk("wrap_out", 32'({out_addr, out_data}), 32'({5'd0, 4'd0}));

        // Step and clear in the same cycle: clear wins, one capture of address 0.
        pulse_step();
        wait_valid(lat);
        chk("step_to_1", 32'({out_addr, out_data}), 32'({5'd1, 4'hA}));
        step = 1'b1; clear = 1'b1;
        @(negedge clk);
        step = 1'b0; clear = 1'b0;
        chk("clear_rd_addr", 32'(rd_addr), 32'd0);
        count_valid(10, cnt);
        chk("clear_single_valid", 32'(cnt), 32'd1);
        chk("clear_out", 32'({out_addr, out_data}), 32'({5'd0, 4'd0}));

        // Reset in the middle of a fetch aborts it.
        pulse_step();
        wait_valid(lat);
        chk("pre_reset_out", 32'({out_addr, out_data}), 32'({5'd1, 4'hA}));
        pulse_step();
        #2 rst_n = 1'b0;
        #1;
        chk("midfetch_reset", 32'({rd_addr, out_addr, out_data, out_valid, busy}),
            32'({5'd0, 5'd0, 4'd0, 1'b0, 1'b1}));
        @(negedge clk);
        rst_n = 1'b1;
        wait_valid(lat);
        chk("post_reset_latency", 32'(lat), 32'd3);
        chk("post_reset_out", 32'({out_addr, out_data, busy}), 32'({5'd0, 4'd0, 1'b0}));
        @(negedge clk);

        // Auto-scan for 40 clocks, then run low.
        run = 1'b1;
        count_valid(40, cnt);
        run = 1'b0;
        count_valid(5, lat);
        chk("auto_advances", 32'(cnt + lat), 32'(EXP_AUTO));
        chk("auto_out", 32'({out_addr, out_data}), 32'(EXP_AUTO_OUT));
        count_valid(20, cnt);
        chk("run_low_idle", 32'(cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
